// File: rtl/ppu_bg_fetcher.sv
// ============================================================================
// ppu_bg_fetcher
// ----------------------------------------------------------------------------
// Background / window tile fetcher for the mode-3 pixel pipeline. Reads a
// tile-map byte and two tile-data bytes from VRAM, then pushes the 8 decoded
// pixels one per cycle into the background pixel FIFO.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ppu_pkg;
    // Pixel record carried through the pixel FIFOs.
    typedef struct packed {
        logic [1:0] color;
        logic [2:0] palette;
        logic       bg_priority;
        logic       is_obj;
    } ppu_pixel_t;
endpackage

module ppu_bg_fetcher
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        window_start,
    input  logic        lcdc_bg_map,
    input  logic        lcdc_tile_data,
    input  logic        lcdc_win_map,
    input  logic [7:0]  ly,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic [7:0]  wlc,
    output logic [12:0] vram_addr,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    input  logic [4:0]  fifo_count,
    input  logic        fifo_full,
    output logic        push_en,
    output ppu_pixel_t  push_px,
    output logic        busy
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_TILE0 = 3'd1;
    localparam logic [2:0] c_ST_TILE1 = 3'd2;
    localparam logic [2:0] c_ST_LO0   = 3'd3;
    localparam logic [2:0] c_ST_LO1   = 3'd4;
    localparam logic [2:0] c_ST_HI0   = 3'd5;
    localparam logic [2:0] c_ST_HI1   = 3'd6;
    localparam logic [2:0] c_ST_PUSH  = 3'd7;

    localparam logic [12:0] c_MAP_LO       = 13'h1800;
    localparam logic [12:0] c_MAP_HI       = 13'h1C00;
    localparam logic [12:0] c_SIGNED_BASE  = 13'h1000;
    localparam logic [4:0]  c_BURST_ROOM   = 5'd8;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_win_mode;
    logic [4:0]  r_fetch_x;
    logic [4:0]  r_win_x;
    logic [7:0]  r_tile;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [2:0]  r_px_idx;

    logic [7:0]  w_bg_y;
    logic [4:0]  w_bg_col;
    logic [2:0]  w_row;
    logic [12:0] w_map_base;
    logic [9:0]  w_map_off;
    logic [12:0] w_map_addr;
    logic [12:0] w_tile_base;
    logic [12:0] w_lo_addr;
    logic [12:0] w_hi_addr;
    logic [2:0]  w_bit_sel;
    logic        w_abort;
    logic        w_burst_ok;
    logic        w_push;

    // Address arithmetic: map entry, tile row and tile-data location.
    always_comb begin
        w_bg_y     = ly + scy;
        // scx low bits cannot carry into bit 3 because fetch_x is added at bit 3.
        w_bg_col   = 5'((scx + {r_fetch_x, 3'b000}) >> 3);
        w_row      = r_win_mode ? wlc[2:0] : w_bg_y[2:0];
        w_map_base = (r_win_mode ? lcdc_win_map : lcdc_bg_map) ? c_MAP_HI : c_MAP_LO;
        w_map_off  = r_win_mode ? {wlc[7:3], r_win_x} : {w_bg_y[7:3], w_bg_col};
        w_map_addr = w_map_base + {3'b000, w_map_off};
        // Signed mode: sign-extended index * 16, offset from 0x1000, 13-bit wrap.
        w_tile_base = lcdc_tile_data ? {1'b0, r_tile, 4'b0000}
                                     : (c_SIGNED_BASE + {r_tile[7], r_tile, 4'b0000});
        w_lo_addr  = w_tile_base + {9'd0, w_row, 1'b0};
        w_hi_addr  = w_tile_base + {9'd0, w_row, 1'b1};
        w_bit_sel  = 3'd7 - r_px_idx;
    end

    // Push qualification: room is checked only on the first pixel of a burst.
    always_comb begin
        w_abort    = stop | start | window_start;
        w_burst_ok = (r_px_idx != 3'd0) || (fifo_count <= c_BURST_ROOM);
        w_push     = (r_state == c_ST_PUSH) && !w_abort && !fifo_full && w_burst_ok;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fetch sequence with stop > start > window_start overrides.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  w_next_state = c_ST_IDLE;
            c_ST_TILE0: w_next_state = c_ST_TILE1;
            c_ST_TILE1: w_next_state = c_ST_LO0;
            c_ST_LO0:   w_next_state = c_ST_LO1;
            c_ST_LO1:   w_next_state = c_ST_HI0;
            c_ST_HI0:   w_next_state = c_ST_HI1;
            c_ST_HI1:   w_next_state = c_ST_PUSH;
            c_ST_PUSH:  w_next_state = (w_push && (r_px_idx == 3'd7)) ? c_ST_TILE0 : c_ST_PUSH;
            default:    w_next_state = c_ST_IDLE;
        endcase
        if (stop) begin
            w_next_state = c_ST_IDLE;
        end else if (start || window_start) begin
            w_next_state = c_ST_TILE0;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        vram_rd   = 1'b0;
        vram_addr = 13'd0;
        push_en   = 1'b0;
        push_px   = '0;
        busy      = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_TILE0: begin
                vram_rd   = 1'b1;
                vram_addr = w_map_addr;
            end
            c_ST_LO0: begin
                vram_rd   = 1'b1;
                vram_addr = w_lo_addr;
            end
            c_ST_HI0: begin
                vram_rd   = 1'b1;
                vram_addr = w_hi_addr;
            end
            c_ST_PUSH: begin
                push_en = w_push;
                if (w_push) begin
                    push_px.color = {r_hi[w_bit_sel], r_lo[w_bit_sel]};
                end
            end
            default: ;
        endcase
    end

    // Datapath: fetched bytes, burst pixel index and tile column counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_mode <= 1'b0;
            r_fetch_x  <= 5'd0;
            r_win_x    <= 5'd0;
            r_tile     <= 8'd0;
            r_lo       <= 8'd0;
            r_hi       <= 8'd0;
            r_px_idx   <= 3'd0;
        end else if (stop) begin
            r_px_idx   <= 3'd0;
        end else if (start) begin
            r_win_mode <= 1'b0;
            r_fetch_x  <= 5'd0;
            r_px_idx   <= 3'd0;
        end else if (window_start) begin
            r_win_mode <= 1'b1;
            r_win_x    <= 5'd0;
            r_px_idx   <= 3'd0;
        end else begin
            case (r_state)
                c_ST_TILE1: r_tile <= vram_data;
                c_ST_LO1:   r_lo   <= vram_data;
                c_ST_HI1:   r_hi   <= vram_data;
                c_ST_PUSH: begin
                    if (w_push) begin
                        r_px_idx <= r_px_idx + 3'd1;
                        if (r_px_idx == 3'd7) begin
                            if (r_win_mode) begin
                                r_win_x <= r_win_x + 5'd1;
                            end else begin
                                r_fetch_x <= r_fetch_x + 5'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ppu_bg_fetcher.sv
// ============================================================================
// tb_ppu_bg_fetcher
// ----------------------------------------------------------------------------
// Self-checking bench for ppu_bg_fetcher: directed scenarios plus randomized
// lines compared against an address/pixel reference model.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppu_bg_fetcher;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        window_start;
    logic        lcdc_bg_map;
    logic        lcdc_tile_data;
    logic        lcdc_win_map;
    logic [7:0]  ly;
    logic [7:0]  scx;
    logic [7:0]  scy;
    logic [7:0]  wlc;
    logic [12:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data = 8'h00;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic        push_en;
    ppu_pixel_t  push_px;
    logic        busy;

    logic [7:0]  vram [0:8191];

    int vectors = 0;
    int errors  = 0;

    ppu_bg_fetcher dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .window_start   (window_start),
        .lcdc_bg_map    (lcdc_bg_map),
        .lcdc_tile_data (lcdc_tile_data),
        .lcdc_win_map   (lcdc_win_map),
        .ly             (ly),
        .scx            (scx),
        .scy            (scy),
        .wlc            (wlc),
        .vram_addr      (vram_addr),
        .vram_rd        (vram_rd),
        .vram_data      (vram_data),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .push_en        (push_en),
        .push_px        (push_px),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // VRAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (vram_rd) vram_data <= vram[vram_addr];
    end

    // ---------------- reference model ----------------
    function automatic int exp_map(bit win, int x);
        int y;
        if (win) return (lcdc_win_map ? 'h1C00 : 'h1800) + (int'(wlc) / 8) * 32 + (x % 32);
        y = (int'(ly) + int'(scy)) % 256;
        return (lcdc_bg_map ? 'h1C00 : 'h1800) + (y / 8) * 32 + ((int'(scx) / 8 + x) % 32);
    endfunction

    function automatic int exp_row(bit win);
        if (win) return int'(wlc) % 8;
        return ((int'(ly) + int'(scy)) % 256) % 8;
    endfunction

    function automatic int exp_data_base(int t);
        int st;
        if (lcdc_tile_data) return t * 16;
        st = (t >= 128) ? t - 256 : t;
        return ('h1000 + st * 16) & 'h1FFF;
    endfunction

    function automatic int exp_color(int lo, int hi, int i);
        return ((hi >> (7 - i)) & 1) * 2 + ((lo >> (7 - i)) & 1);
    endfunction

    function automatic ppu_pixel_t mk_px(int col);
        ppu_pixel_t p;
        p = '0;
        p.color = 2'(col);
        return p;
    endfunction

    // Colors of tile n in the current mode, straight from VRAM contents.
    function automatic int tile_color(bit win, int n, int i);
        int b;
        b = exp_data_base(int'(vram[exp_map(win, n)])) + exp_row(win) * 2;
        return exp_color(int'(vram[b]), int'(vram[b + 1]), i);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic fill_vram;
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
    endtask

    task automatic end_line;
        @(posedge clk); #1;
        stop = 1'b1; window_start = 1'b0; start = 1'b0;
        fifo_count = 5'd0; fifo_full = 1'b0;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic set_regs(bit bgm, bit td, bit wm, int l, int sx, int sy, int w);
        lcdc_bg_map = bgm; lcdc_tile_data = td; lcdc_win_map = wm;
        ly = 8'(l); scx = 8'(sx); scy = 8'(sy); wlc = 8'(w);
        fifo_count = 5'd0; fifo_full = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (vram_addr !== 13'd0 || vram_rd !== 1'b0 || push_en !== 1'b0 ||
            push_px !== mk_px(0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%h rd=%b push=%b px=%h busy=%b, expected all zero",
                     vram_addr, vram_rd, push_en, push_px, busy);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_start: busy=%b, expected 0", busy);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || vram_rd !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rd=%b, expected 0 0", busy, vram_rd);
        end
    endtask

    task automatic test_basic_tile;
        int col[8] = '{3, 3, 1, 1, 2, 2, 0, 0};
        bit er, ep;
        int ea;
        @(posedge clk); #1;
        set_regs(0, 1, 0, 0, 0, 0, 0);
        vram[13'h1800] = 8'h02; vram[13'h0020] = 8'hF0; vram[13'h0021] = 8'hCC;
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            er = (c == 1 || c == 3 || c == 5 || c == 15);
            ep = (c >= 7 && c <= 14);
            vectors++;
            if (vram_rd !== er || push_en !== ep || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_strobes c%0d: rd=%b push=%b busy=%b, expected %b %b 1",
                         c, vram_rd, push_en, busy, er, ep);
            end
            if (er) begin
                ea = (c == 1) ? 'h1800 : (c == 3) ? 'h0020 : (c == 5) ? 'h0021 : 'h1801;
                vectors++;
                if (vram_addr !== 13'(ea)) begin
                    errors++;
                    $display("FAIL basic_addr c%0d: addr=%h, expected %h", c, vram_addr, ea);
                end
            end
            if (ep) begin
                vectors++;
                if (push_px !== mk_px(col[c - 7])) begin
                    errors++;
                    $display("FAIL basic_pixel c%0d: px=%h, expected color %0d", c, push_px, col[c - 7]);
                end
            end
        end
        end_line();
    endtask

    task automatic test_signed_addr;
        @(posedge clk); #1;
        set_regs(0, 0, 0, 3, 0, 2, 0);
        vram[13'h1800] = 8'h80;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (c == 3 || c == 5) begin
                vectors++;
                if (vram_rd !== 1'b1 || vram_addr !== ((c == 3) ? 13'h080A : 13'h080B)) begin
                    errors++;
                    $display("FAIL signed_addr c%0d: rd=%b addr=%h, expected 1 %h", c, vram_rd,
                             vram_addr, (c == 3) ? 13'h080A : 13'h080B);
                end
            end
        end
        end_line();
    endtask

    task automatic test_scroll_wrap;
        @(posedge clk); #1;
        set_regs(0, 1, 0, 0, 8'hF8, 0, 0);
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (c == 1 || c == 15) begin
                vectors++;
                if (vram_rd !== 1'b1 || vram_addr !== ((c == 1) ? 13'h181F : 13'h1800)) begin
                    errors++;
                    $display("FAIL scroll_wrap c%0d: rd=%b addr=%h, expected 1 %h", c, vram_rd,
                             vram_addr, (c == 1) ? 13'h181F : 13'h1800);
                end
            end
        end
        end_line();
    endtask

    task automatic test_backpressure;
        bit ep;
        int k;
        // Room check at burst start.
        @(posedge clk); #1;
        set_regs(0, 1, 0, 5, 16, 7, 0);
        fifo_count = 5'd12;
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) fifo_count = 5'd8;
            @(negedge clk);
            ep = (c >= 10 && c <= 17);
            vectors++;
            if (push_en !== ep || (ep && push_px !== mk_px(tile_color(0, 0, c - 10)))) begin
                errors++;
                $display("FAIL bp_count c%0d: push=%b px=%h, expected %b color %0d", c, push_en,
                         push_px, ep, ep ? tile_color(0, 0, c - 10) : 0);
            end
        end
        end_line();
        // fifo_full mid-burst: pixel 3 must wait, nothing lost or repeated.
        @(posedge clk); #1;
        set_regs(0, 1, 0, 5, 16, 7, 0);
        start = 1'b1;
        k = 0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            fifo_full = (c == 10 || c == 11);
            @(negedge clk);
            ep = (c >= 7 && c <= 9) || (c >= 12 && c <= 16);
            vectors++;
            if (push_en !== ep) begin
                errors++;
                $display("FAIL bp_full_strobe c%0d: push=%b, expected %b", c, push_en, ep);
            end
            if (push_en) begin
                vectors++;
                if (k > 7 || push_px !== mk_px(tile_color(0, 0, k))) begin
                    errors++;
                    $display("FAIL bp_full_pixel %0d: px=%h, expected color %0d", k, push_px,
                             (k > 7) ? 0 : tile_color(0, 0, k));
                end
                k++;
            end
        end
        vectors++;
        if (k !== 8) begin
            errors++;
            $display("FAIL bp_full_total: pushed %0d, expected 8", k);
        end
        end_line();
    endtask

    task automatic test_window;
        bit ep;
        int b;
        @(posedge clk); #1;
        set_regs(0, 1, 1, 0, 0, 0, 9);
        start = 1'b1;
        b = exp_data_base(int'(vram[13'h1C20]));
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            window_start = (c == 4);
            @(negedge clk);
            ep = (c >= 11 && c <= 18);
            vectors++;
            if (push_en !== ep || (ep && push_px !== mk_px(tile_color(1, 0, c - 11)))) begin
                errors++;
                $display("FAIL window_push c%0d: push=%b px=%h, expected %b color %0d", c, push_en,
                         push_px, ep, ep ? tile_color(1, 0, c - 11) : 0);
            end
            if (c == 5 || c == 7 || c == 9 || c == 19) begin
                vectors++;
                if (vram_rd !== 1'b1 || vram_addr !== ((c == 5) ? 13'h1C20 : (c == 7) ? 13'(b + 2) :
                                                       (c == 9) ? 13'(b + 3) : 13'h1C21)) begin
                    errors++;
                    $display("FAIL window_addr c%0d: rd=%b addr=%h, expected 1 %h", c, vram_rd, vram_addr,
                             (c == 5) ? 13'h1C20 : (c == 7) ? 13'(b + 2) : (c == 9) ? 13'(b + 3) : 13'h1C21);
                end
            end
        end
        end_line();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_priority;
        @(posedge clk); #1;
        set_regs(0, 1, 1, 0, 0, 0, 0);
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_stop_start: busy=%b, expected 0", busy);
        end
        start = 1'b1; window_start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; window_start = 1'b0;
        vectors++;
        if (vram_rd !== 1'b1 || vram_addr !== 13'h1800) begin
            errors++;
            $display("FAIL prio_start_window: rd=%b addr=%h, expected 1 1800", vram_rd, vram_addr);
        end
        end_line();
    endtask

    task automatic test_reset_midburst;
        @(posedge clk); #1;
        set_regs(0, 1, 0, 1, 2, 3, 0);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        vectors++;
        if (push_en !== 1'b1) begin
            errors++;
            $display("FAIL midburst_pre: push=%b, expected 1", push_en);
        end
        reset = 1'b1;
        #2;
        vectors++;
        if (push_en !== 1'b0 || busy !== 1'b0 || vram_rd !== 1'b0 || push_px !== mk_px(0)) begin
            errors++;
            $display("FAIL midburst_async: push=%b busy=%b rd=%b px=%h, expected 0 0 0 0",
                     push_en, busy, vram_rd, push_px);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (push_en !== 1'b0 || busy !== 1'b0 || vram_rd !== 1'b0) begin
                errors++;
                $display("FAIL post_reset c%0d: push=%b busy=%b rd=%b, expected 0 0 0",
                         c, push_en, busy, vram_rd);
            end
        end
    endtask

    task automatic test_random;
        int rdq[$];
        int pxq[$];
        int m, b, rd_i, px_i, c;
        bit win;
        for (int it = 0; it < 8; it++) begin
            @(posedge clk); #1;
            fill_vram();
            set_regs($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 143), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 143));
            win = 1'($urandom_range(0, 1));
            rdq.delete();
            pxq.delete();
            // With a window run, the BG map read of cycle 1 is issued before window_start lands.
            if (win) rdq.push_back(exp_map(0, 0));
            for (int n = 0; n < 5; n++) begin
                m = exp_map(win, n);
                b = exp_data_base(int'(vram[m])) + exp_row(win) * 2;
                rdq.push_back(m);
                rdq.push_back(b);
                rdq.push_back(b + 1);
                if (n < 3) for (int i = 0; i < 8; i++) pxq.push_back(tile_color(win, n, i));
            end
            start = 1'b1;
            rd_i = 0; px_i = 0; c = 0;
            while (px_i < 24 && c < 400) begin
                @(posedge clk); #1;
                c++;
                start = 1'b0;
                window_start = win && (c == 1);
                fifo_count = 5'($urandom_range(0, 16));
                fifo_full = (fifo_count == 5'd16) || ($urandom_range(0, 5) == 0);
                @(negedge clk);
                if (vram_rd && push_en) begin
                    vectors++;
                    errors++;
                    $display("FAIL rnd_overlap it%0d c%0d: rd and push both high", it, c);
                end
                if (vram_rd) begin
                    vectors++;
                    if (rd_i >= rdq.size() || vram_addr !== 13'(rdq[rd_i])) begin
                        errors++;
                        $display("FAIL rnd_addr it%0d read %0d: addr=%h, expected %h", it, rd_i,
                                 vram_addr, (rd_i < rdq.size()) ? rdq[rd_i] : -1);
                    end
                    rd_i++;
                end
                if (push_en) begin
                    vectors++;
                    if (fifo_full || ((px_i % 8) == 0 && fifo_count > 5'd8) ||
                        push_px !== mk_px(pxq[px_i])) begin
                        errors++;
                        $display("FAIL rnd_pixel it%0d px %0d: px=%h full=%b cnt=%0d, expected color %0d",
                                 it, px_i, push_px, fifo_full, fifo_count, pxq[px_i]);
                    end
                    px_i++;
                end
            end
            vectors++;
            if (px_i < 24) begin
                errors++;
                $display("FAIL rnd_timeout it%0d: pushed %0d, expected 24", it, px_i);
            end
            end_line();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; window_start = 1'b0;
        set_regs(0, 0, 0, 0, 0, 0, 0);
        fill_vram();
        test_reset();
        test_basic_tile();
        test_signed_addr();
        test_scroll_wrap();
        test_backpressure();
        test_window();
        test_priority();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
